// File: rtl/id_inst_queue.sv
// Instruction queue between IF and ID: circular buffer of {pc, inst} with flush and delay-slot retention.
// Optional ID_IQ_BYPASS_EN lets an offer into an empty queue reach ID in the same cycle.
module id_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INST_W-1:0]        in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INST_W-1:0]        out_inst,
  input  logic                     flush,
  input  logic                     flush_keep,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     keep_ptr;
  logic              empty;
  logic              bypass;
  logic              push_acc;
  logic              push_wr;
  logic              pop_q;
  logic              keep_old;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign in_ready = (count < DEPTH_P);

`ifdef ID_IQ_BYPASS_EN
  assign bypass = empty & in_valid;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = !empty | bypass;
  assign out_pc    = bypass ? in_pc   : pc_mem[rd_ptr[AW-1:0]];
  assign out_inst  = bypass ? in_inst : inst_mem[rd_ptr[AW-1:0]];

  assign push_acc = in_valid & in_ready;
  assign pop_q    = !empty & out_ready;
  // A bypassed entry taken by ID is consumed without ever being stored.
  assign push_wr  = push_acc & ~(bypass & out_ready);

  // Oldest surviving stored entry after this cycle's pop.
  assign keep_ptr = rd_ptr + PW'(pop_q);
  assign keep_old = (count > PW'(pop_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      if (!flush_keep) begin
        rd_ptr <= wr_ptr;
      end else if (keep_old) begin
        rd_ptr <= keep_ptr;
        wr_ptr <= keep_ptr + ONE_P;
      end else if (push_wr) begin
        rd_ptr <= wr_ptr;
        wr_ptr <= wr_ptr + ONE_P;
      end else begin
        rd_ptr <= wr_ptr;
      end
    end else begin
      if (push_wr) wr_ptr <= wr_ptr + ONE_P;
      if (pop_q)   rd_ptr <= rd_ptr + ONE_P;
    end
  end

  // Storage needs no reset; a write that a flush discards is never read.
  always_ff @(posedge clk) begin
    if (push_wr) begin
      pc_mem[wr_ptr[AW-1:0]]   <= in_pc;
      inst_mem[wr_ptr[AW-1:0]] <= in_inst;
    end
  end

endmodule

// File: tb/tb_id_inst_queue.sv
// Scoreboard bench for id_inst_queue (DEPTH=4); follows ID_IQ_BYPASS_EN when defined.
module tb_id_inst_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        flush = 1'b0;
  logic        flush_keep = 1'b0;
  logic [2:0]  count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  id_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .flush(flush), .flush_keep(flush_keep), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Drive one cycle at the falling edge, check outputs, update the model, advance to next falling edge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic r,
                       input logic f, input logic k);
    int   size0;
    bit   byp;
    ent_t e;
    in_valid = v; in_pc = pc; in_inst = inst_of(pc);
    out_ready = r; flush = f; flush_keep = k;
    #1;
    size0 = sb.size();
    byp = 1'b0;
`ifdef ID_IQ_BYPASS_EN
    byp = (size0 == 0) && v;
`endif
    check_eq("count", 64'(count), 64'(size0));
    check_eq("in_ready", 64'(in_ready), 64'(size0 < DEPTH));
    check_eq("out_valid", 64'(out_valid), 64'((size0 != 0) || byp));
    if (byp) begin
      check_eq("bypass_pc", 64'(out_pc), 64'(pc));
      check_eq("bypass_inst", 64'(out_inst), 64'(inst_of(pc)));
    end else if (size0 != 0) begin
      check_eq("head_pc", 64'(out_pc), 64'(sb[0].pc));
      check_eq("head_inst", 64'(out_inst), 64'(sb[0].inst));
    end
    if (!(byp && r)) begin
      if (r && size0 != 0) void'(sb.pop_front());
      if (v && size0 < DEPTH) begin
        e.pc = pc; e.inst = inst_of(pc);
        sb.push_back(e);
      end
    end
    if (f) begin
      if (!k) sb.delete();
      else while (sb.size() > 1) void'(sb.pop_back());
    end
    @(negedge clk);
  endtask

  initial begin
    #12;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fill to full while ID stalls, then a fifth offer that must be refused.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    check_eq("fill_count", 64'(count), 64'd4);
    check_eq("fill_in_ready", 64'(in_ready), 64'd0);
    check_eq("fill_head", 64'(out_pc), 64'h100);
    cycle(1'b1, 32'h110, 1'b0, 1'b0, 1'b0);
    // Full queue with push+pop offered: only the pop happens.
    cycle(1'b1, 32'h110, 1'b1, 1'b0, 1'b0);
    check_eq("fullpp_count", 64'(count), 64'd3);
    check_eq("fullpp_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Wrap-around with continuous push/pop pairs.
    cycle(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) cycle(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush keeping the delay slot while the head pops.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    check_eq("keep_count", 64'(count), 64'd1);
    check_eq("keep_pc", 64'(out_pc), 64'h304);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Plain flush discards a concurrent push.
    cycle(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h504, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h508, 1'b0, 1'b1, 1'b0);
    check_eq("flush_count", 64'(count), 64'd0);
    check_eq("flush_out_valid", 64'(out_valid), 64'd0);

    // Keep falls back to the pushed entry when the only stored one pops.
    cycle(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h604, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Random traffic including flushes.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 3) != 0), 32'h1000 + 32'(4 * i), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));

    // Asynchronous reset between edges mid-burst.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h700 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_eq("arst_count", 64'(count), 64'd0);
    check_eq("arst_out_valid", 64'(out_valid), 64'd0);
    check_eq("arst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Empty queue offer: one-cycle latency, or same-cycle consumption with bypass.
    cycle(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
`ifdef ID_IQ_BYPASS_EN
    check_eq("bypass_count", 64'(count), 64'd0);
`else
    check_eq("latency_pc", 64'(out_pc), 64'h400);
    check_eq("latency_count", 64'(count), 64'd1);
`endif
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
